// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode and state types for the ALU operation sequencer
package alu_seq_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_AND, OP_NOT, OP_PASS, OP_MUL, OP_DIV} alu_op_t;
  typedef enum logic [2:0] {IDLE, EXEC, DIV_GO, DIV_WAIT, RESP} seq_state_t;
  localparam logic [2:0] OP_LAST_LEGAL = 3'b101;
endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU op per request, waits out divider latency, returns captured result
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DIV_LATENCY = 17,
  parameter int CNT_W       = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [2:0]  alu_select,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_div_start,
  input  logic [15:0] alu_data,
  input  logic [15:0] alu_aux,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_aux,
  output logic        rsp_err
);
  seq_state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic accept, err_op, capture;
  assign accept  = req_valid && req_ready;
  assign err_op  = req_op > OP_LAST_LEGAL || (req_op == OP_DIV && req_b == '0);
  assign capture = state == EXEC || (state == DIV_WAIT && cnt == '0);
  always_comb begin
    state_nx      = state;
    req_ready     = state == IDLE;
    rsp_valid     = state == RESP;
    alu_div_start = state == DIV_GO;
    unique case (state)
      IDLE:     state_nx = !accept ? IDLE : err_op ? RESP : req_op == OP_DIV ? DIV_GO : EXEC;
      EXEC:     state_nx = RESP;
      DIV_GO:   state_nx = DIV_WAIT;
      DIV_WAIT: state_nx = cnt == '0 ? RESP : DIV_WAIT;
      RESP:     state_nx = rsp_ready ? IDLE : RESP;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_select <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_data   <= '0;
      rsp_aux    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        alu_select <= req_op;
        alu_a      <= req_a;
        alu_b      <= req_b;
      end
      if (accept && err_op) begin
        rsp_data <= '0;
        rsp_aux  <= '0;
        rsp_err  <= 1'b1;
      end
      if (capture) begin
        rsp_data <= alu_data;
        rsp_aux  <= alu_aux;
        rsp_err  <= 1'b0;
      end
      if (state == DIV_GO) cnt <= CNT_W'(DIV_LATENCY - 1);
      else if (state == DIV_WAIT) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with a behavioural ALU and reference model
module tb_alu_op_sequencer;
  localparam int DIV_LAT = 17;
  typedef struct {
    logic [15:0] d;
    logic [15:0] x;
    logic        e;
    int          lat;
    int          ds;
    int          acc;
  } exp_t;
  logic        Clk, Reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [2:0]  alu_select;
  logic [15:0] alu_a, alu_b, alu_data, alu_aux;
  logic        alu_div_start;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data, rsp_aux;
  logic        hold_rdy, rand_bp, rnd_rdy;
  int          checks, errors, cyc, hs_cyc, last_acc, ds_cnt;
  bit          have;
  exp_t        q[$];
  exp_t        cur;
  logic [31:0] prod;
  logic [15:0] div_q, div_r, div_a, div_b;
  int          div_cnt;
  alu_op_sequencer #(.DIV_LATENCY(DIV_LAT), .CNT_W(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_div_start(alu_div_start),
    .alu_data(alu_data), .alu_aux(alu_aux),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_aux(rsp_aux), .rsp_err(rsp_err)
  );
  initial Clk = 0;
  always #5 Clk = ~Clk;
  assign rsp_ready = rand_bp ? rnd_rdy : hold_rdy;
  always @(negedge Clk) rnd_rdy = $urandom_range(0, 3) != 0;
  assign prod = {16'b0, alu_a} * {16'b0, alu_b};
  always_comb begin
    alu_data = 16'h0;
    alu_aux  = 16'h0;
    case (alu_select)
      3'd0: alu_data = alu_a + alu_b;
      3'd1: alu_data = alu_a & alu_b;
      3'd2: alu_data = ~alu_a;
      3'd3: alu_data = alu_a;
      3'd4: begin alu_data = prod[15:0]; alu_aux = prod[31:16]; end
      3'd5: begin alu_data = div_q; alu_aux = div_r; end
      default: ;
    endcase
  end
  always @(posedge Clk) begin
    if (Reset) div_cnt <= 0;
    else if (alu_div_start) begin
      div_cnt <= DIV_LAT - 1;
      div_a   <= alu_a;
      div_b   <= alu_b;
      div_q   <= 16'hDEAD;
      div_r   <= 16'hBEEF;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) begin
        div_q <= div_b == 0 ? 16'hFFFF : div_a / div_b;
        div_r <= div_b == 0 ? div_a : div_a % div_b;
      end
    end
  end
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int acc);
    exp_t r;
    logic [31:0] p;
    r.d = 0; r.x = 0; r.e = 0; r.lat = 2; r.ds = 0; r.acc = acc;
    p = {16'b0, a} * {16'b0, b};
    case (op)
      3'd0: r.d = a + b;
      3'd1: r.d = a & b;
      3'd2: r.d = ~a;
      3'd3: r.d = a;
      3'd4: begin r.d = p[15:0]; r.x = p[31:16]; end
      3'd5: if (b == 0) begin r.e = 1; r.lat = 1; end
            else begin r.d = a / b; r.x = a % b; r.lat = DIV_LAT + 2; r.ds = 1; end
      default: begin r.e = 1; r.lat = 1; end
    endcase
    return r;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, want);
    end
  endtask
  always @(negedge Clk) begin
    #1;
    cyc++;
    if (Reset) begin
      ds_cnt = 0;
      have = 0;
    end else begin
      if (alu_div_start) ds_cnt++;
      if (rsp_valid || alu_div_start) chk("ready_while_busy", req_ready, 0);
      if (rsp_valid && !have) begin
        if (q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          cur = q.pop_front();
          have = 1;
          chk("rsp_data", rsp_data, cur.d);
          chk("rsp_aux", rsp_aux, cur.x);
          chk("rsp_err", rsp_err, cur.e);
          chk("latency", cyc - cur.acc, cur.lat);
          chk("div_starts", ds_cnt, cur.ds);
          ds_cnt = 0;
        end
      end else if (rsp_valid) begin
        chk("hold_data", rsp_data, cur.d);
        chk("hold_aux", rsp_aux, cur.x);
        chk("hold_err", rsp_err, cur.e);
      end
      if (!rsp_valid) have = 0;
      if (rsp_valid && rsp_ready) hs_cyc = cyc;
    end
  end
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bit ok = 0;
    @(negedge Clk);
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (req_ready) begin
        @(posedge Clk);
        ok = 1;
        last_acc = cyc;
        q.push_back(model(op, a, b, cyc));
      end else @(negedge Clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(negedge Clk);
    req_valid = 0;
    req_op = $urandom_range(0, 7);
    req_a = $urandom;
    req_b = $urandom;
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || rsp_valid) && t < 3000) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 3000) chk("drain_timeout", 0, 1);
  endtask
  initial begin
    checks = 0; errors = 0; cyc = 0; hs_cyc = -10; ds_cnt = 0; have = 0;
    Reset = 1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0;
    hold_rdy = 1; rand_bp = 0;
    repeat (3) @(negedge Clk);
    Reset = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_div_start", alu_div_start, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_select", alu_select, 0);
    issue(3'd0, 16'h1234, 16'h0001);
    issue(3'd4, 16'h0100, 16'h0100);
    issue(3'd4, 16'hFFFF, 16'hFFFF);
    issue(3'd5, 16'd100, 16'd7);
    issue(3'd5, 16'h0055, 16'h0000);
    issue(3'd6, 16'h1111, 16'h2222);
    issue(3'd7, 16'h3333, 16'h4444);
    drain();
    hold_rdy = 0;
    issue(3'd2, 16'h00FF, 16'h0000);
    repeat (10) @(negedge Clk);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_data", rsp_data, 16'hFF00);
    fork
      issue(3'd1, 16'hAAAA, 16'h0F0F);
      begin
        repeat (3) @(negedge Clk);
        hold_rdy = 1;
      end
    join
    chk("bp_accept_cycle", last_acc, hs_cyc + 1);
    drain();
    issue(3'd5, 16'd1000, 16'd3);
    repeat (6) @(negedge Clk);
    Reset = 1;
    q.delete();
    @(negedge Clk);
    Reset = 0;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_div_start", alu_div_start, 0);
    chk("midrst_alu_select", alu_select, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    issue(3'd1, 16'hF0F0, 16'h0FF0);
    drain();
    rand_bp = 1;
    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 7) == 0 ? 16'h0 : 16'($urandom));
    drain();
    rand_bp = 0;
    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
